xnor_stream_checker: RTL and testbench

Parametrised, pipelined XNOR comparator for streaming data. Each accepted beat compares two WIDTH-bit operands bit by bit. It produces the registered XNOR vector and a word-equal flag. It also keeps a saturating mismatch counter and a pass/fail verdict state machine. It sits between a data source and its golden-model stream in self-check and BIST paths, and supersedes the single-bit combinational XNOR gate.

---
 rtl/xnor_chk_pkg.sv | 16 +
 rtl/xnor_popcount.sv | 25 ++
 rtl/xnor_stream_checker.sv | 143 ++++++++++++++
 tb/tb_xnor_stream_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/xnor_chk_pkg.sv
// Shared types and helpers for the XNOR stream checker.
//   verdict_t : pass/fail verdict encoding (IDLE, PASS, FAIL)
//   cnt_w_for : bits needed to hold a count of 0..width
package xnor_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PASS = 2'b01,
      FAIL = 2'b10
   } verdict_t;

   function automatic int unsigned cnt_w_for(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Only used when XNOR_CHK_POPCOUNT_EN is defined.
// Ports:
//   bits  in   WIDTH            vector to count
//   count out  cnt_w_for(WIDTH) number of ones in bits
module xnor_popcount
   import xnor_chk_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]                  bits,
   output logic [cnt_w_for(WIDTH)-1:0]       count
);

   localparam int unsigned OutW = cnt_w_for(WIDTH);

   // Linear sum; synthesis flattens and balances it into an adder tree.
   always_comb begin
      count = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         count = count + OutW'(bits[i]);
      end
   end

endmodule

// File: rtl/xnor_stream_checker.sv
// Pipelined, masked XNOR comparator for a valid/ready stream. Each accepted
// beat registers ~(a^b)|~mask and its AND-reduction, bumps a saturating
// mismatch counter and advances a sticky pass/fail verdict.
// Optional feature macro: XNOR_CHK_POPCOUNT_EN adds match_cnt (ones in xnor_o).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr                 sync clear of counter and verdict (beat still applies)
//   in_valid/in_ready   input handshake
//   a, b, mask          operands and per-bit compare enable
//   out_valid/out_ready output handshake
//   xnor_o, eq_o        registered result vector and word-equal flag
//   mismatch_cnt        saturating count of mismatching accepted beats
//   verdict             00 IDLE, 01 PASS, 10 FAIL
//   match_cnt           (optional) registered popcount of xnor_o
module xnor_stream_checker
   import xnor_chk_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   input  logic [WIDTH-1:0]      mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      xnor_o,
   output logic                  eq_o,
   output logic [CNT_W-1:0]      mismatch_cnt,
   output logic [1:0]            verdict
`ifdef XNOR_CHK_POPCOUNT_EN
   ,
   output logic [cnt_w_for(WIDTH)-1:0] match_cnt
`endif
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic              accept;
   logic [WIDTH-1:0]  xnor_d;
   logic              eq_d;
   logic [CNT_W-1:0]  cnt_base;
   logic [CNT_W-1:0]  cnt_d;

   logic [WIDTH-1:0]  xnor_q;
   logic              eq_q;
   logic              valid_q;
   logic [CNT_W-1:0]  cnt_q;
   verdict_t          verdict_q;

   // Single register stage without skid buffer: accept only when the slot
   // is empty or is being drained this cycle.
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Masked-off bits are forced to match.
   assign xnor_d = ~(a ^ b) | ~mask;
   assign eq_d   = &xnor_d;

   // Clear takes effect before the same-cycle beat is applied.
   always_comb begin
      cnt_base = clr ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (accept && !eq_d && (cnt_base != CntMax)) begin
         cnt_d = cnt_base + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xnor_q  <= '0;
         eq_q    <= 1'b0;
         valid_q <= 1'b0;
      end else if (accept) begin
         xnor_q  <= xnor_d;
         eq_q    <= eq_d;
         valid_q <= 1'b1;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Verdict FSM; FAIL is sticky until clr or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         verdict_q <= IDLE;
      end else if (accept) begin
         if (!eq_d) begin
            verdict_q <= FAIL;
         end else begin
            unique case (clr ? IDLE : verdict_q)
               IDLE:    verdict_q <= PASS;
               PASS:    verdict_q <= PASS;
               FAIL:    verdict_q <= FAIL;
               default: verdict_q <= IDLE;
            endcase
         end
      end else if (clr) begin
         verdict_q <= IDLE;
      end
   end

   assign xnor_o       = xnor_q;
   assign eq_o         = eq_q;
   assign out_valid    = valid_q;
   assign mismatch_cnt = cnt_q;
   assign verdict      = verdict_q;

`ifdef XNOR_CHK_POPCOUNT_EN
   logic [cnt_w_for(WIDTH)-1:0] pop_d;
   logic [cnt_w_for(WIDTH)-1:0] pop_q;

   xnor_popcount #(
      .WIDTH (WIDTH)
   ) u_popcount (
      .bits  (xnor_d),
      .count (pop_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_q <= '0;
      end else if (accept) begin
         pop_q <= pop_d;
      end
   end

   assign match_cnt = pop_q;
`endif

endmodule

// File: tb/tb_xnor_stream_checker.sv
// Directed bench for xnor_stream_checker. A second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_xnor_stream_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] a, b, mask;

   logic        in_ready, out_valid, eq_o;
   logic [7:0]  xnor_o;
   logic [15:0] mismatch_cnt;
   logic [1:0]  verdict;

   logic        s_in_ready, s_out_valid, s_eq_o;
   logic [7:0]  s_xnor_o;
   logic [1:0]  s_mismatch_cnt;
   logic [1:0]  s_verdict;

`ifdef XNOR_CHK_POPCOUNT_EN
   logic [3:0] match_cnt;
   logic [3:0] s_match_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   xnor_stream_checker #(.WIDTH(8), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .a            (a),
      .b            (b),
      .mask         (mask),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .xnor_o       (xnor_o),
      .eq_o         (eq_o),
      .mismatch_cnt (mismatch_cnt),
      .verdict      (verdict)
`ifdef XNOR_CHK_POPCOUNT_EN
      ,
      .match_cnt    (match_cnt)
`endif
   );

   xnor_stream_checker #(.WIDTH(8), .CNT_W(2)) dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (clr),
      .in_valid     (in_valid),
      .in_ready     (s_in_ready),
      .a            (a),
      .b            (b),
      .mask         (mask),
      .out_valid    (s_out_valid),
      .out_ready    (out_ready),
      .xnor_o       (s_xnor_o),
      .eq_o         (s_eq_o),
      .mismatch_cnt (s_mismatch_cnt),
      .verdict      (s_verdict)
`ifdef XNOR_CHK_POPCOUNT_EN
      ,
      .match_cnt    (s_match_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tm);
      a        = ta;
      b        = tb;
      mask     = tm;
      in_valid = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; mask = '0;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_xnor", 32'(xnor_o), 32'h00);
      check("rst_eq", 32'(eq_o), 32'd0);
      check("rst_cnt", 32'(mismatch_cnt), 32'd0);
      check("rst_verdict", 32'(verdict), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      step();

      // Equal operands
      drive(8'hA5, 8'hA5, 8'hFF); step();
      check("eq_xnor", 32'(xnor_o), 32'hFF);
      check("eq_eq", 32'(eq_o), 32'd1);
      check("eq_verdict", 32'(verdict), 32'd1);
      check("eq_cnt", 32'(mismatch_cnt), 32'd0);
      check("eq_valid", 32'(out_valid), 32'd1);

      // Full mismatch
      drive(8'hF0, 8'h0F, 8'hFF); step();
      check("mm_xnor", 32'(xnor_o), 32'h00);
      check("mm_eq", 32'(eq_o), 32'd0);
      check("mm_verdict", 32'(verdict), 32'd2);
      check("mm_cnt", 32'(mismatch_cnt), 32'd1);

      // FAIL is sticky
      drive(8'hA5, 8'hA5, 8'hFF); step();
      check("sticky_verdict", 32'(verdict), 32'd2);
      check("sticky_eq", 32'(eq_o), 32'd1);

      // Masked-off differing bit
      drive(8'h01, 8'h00, 8'hFE); step();
      check("mask_xnor", 32'(xnor_o), 32'hFF);
      check("mask_eq", 32'(eq_o), 32'd1);
      check("mask_cnt", 32'(mismatch_cnt), 32'd1);

      // Backpressure: nothing accepted while out_ready is low
      out_ready = 1'b0;
      drive(8'hF0, 8'h0F, 8'hFF);
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_xnor", 32'(xnor_o), 32'hFF);
         check("stall_cnt", 32'(mismatch_cnt), 32'd1);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", 32'(in_ready), 32'd1);
      step();
      check("resume_xnor", 32'(xnor_o), 32'h00);
      check("resume_cnt", 32'(mismatch_cnt), 32'd2);
      step();
      check("resume_cnt2", 32'(mismatch_cnt), 32'd3);
      check("sat_cnt_a", 32'(s_mismatch_cnt), 32'd3);
      step();
      step();
      check("more_cnt", 32'(mismatch_cnt), 32'd5);
      check("sat_cnt_b", 32'(s_mismatch_cnt), 32'd3);

      // Clear together with an equal beat
      clr = 1'b1;
      drive(8'hA5, 8'hA5, 8'hFF); step();
      check("clr_beat_cnt", 32'(mismatch_cnt), 32'd0);
      check("clr_beat_sat_cnt", 32'(s_mismatch_cnt), 32'd0);
      check("clr_beat_verdict", 32'(verdict), 32'd1);
      check("clr_beat_xnor", 32'(xnor_o), 32'hFF);

      // Clear alone; output drains but holds data
      in_valid = 1'b0; step();
      clr = 1'b0;
      check("clr_only_verdict", 32'(verdict), 32'd0);
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_xnor_hold", 32'(xnor_o), 32'hFF);
      check("drain_eq_hold", 32'(eq_o), 32'd1);

      // All-zero mask always matches
      drive(8'h3C, 8'hC3, 8'h00); step();
      check("zero_mask_eq", 32'(eq_o), 32'd1);
      check("zero_mask_verdict", 32'(verdict), 32'd1);

      // Partial match, popcount case
      drive(8'hAA, 8'hA0, 8'hFF); step();
      check("part_xnor", 32'(xnor_o), 32'hF5);
      check("part_cnt", 32'(mismatch_cnt), 32'd1);
      check("part_verdict", 32'(verdict), 32'd2);
`ifdef XNOR_CHK_POPCOUNT_EN
      check("popcount", 32'(match_cnt), 32'd6);
`endif

      // Asynchronous reset mid-stream
      drive(8'h11, 8'h11, 8'hFF);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_xnor", 32'(xnor_o), 32'h00);
      check("arst_cnt", 32'(mismatch_cnt), 32'd0);
      check("arst_verdict", 32'(verdict), 32'd0);
`ifdef XNOR_CHK_POPCOUNT_EN
      check("arst_popcount", 32'(match_cnt), 32'd0);
`endif
      in_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_verdict", 32'(verdict), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
